// File: rtl/timer_pkg.sv
// Shared definitions for the programmable interval timer: FSM encoding,
// register offsets and CTRL bit positions.
package timer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } state_e;

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrPreset = 2'd1;
    localparam logic [1:0] AddrCount  = 2'd2;

    localparam int unsigned CtrlEnBit   = 0;
    localparam int unsigned CtrlModeLsb = 1;
    localparam int unsigned CtrlModeMsb = 2;
    localparam int unsigned CtrlImBit   = 3;
    localparam int unsigned CtrlPendBit = 4;

    localparam logic [1:0] ModeOneShot = 2'b00;
    localparam logic [1:0] ModeReload  = 2'b01;

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable, registered interrupt request.
module timer_dev
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic               en_q, en_d;
    logic [1:0]         mode_q, mode_d;
    logic               im_q, im_d;
    logic               pend_q, pend_d;
    logic               irq_q;

    logic               ctrl_wr;
    logic               preset_wr;
    logic               en_eff;

    assign ctrl_wr   = we && (addr == AddrCtrl);
    assign preset_wr = we && (addr == AddrPreset);
    // A CTRL write steers the FSM on the same edge it lands, so pausing freezes COUNT at once.
    assign en_eff    = ctrl_wr ? din[CtrlEnBit] : en_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        preset_d = preset_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        pend_d   = pend_q;

        case (state_q)
            StIdle: begin
                if (en_eff) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (en_eff) begin
                    count_d = preset_q;
                    state_d = StCnt;
                end
            end
            StCnt: begin
                if (en_eff) begin
                    if (count_q > CNT_W'(1)) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        count_d = '0;
                        state_d = StInt;
                    end
                end
            end
            StInt: begin
                if (mode_q == ModeReload) begin
                    state_d = StLoad;
                end else begin
                    en_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Register writes come after the FSM so a software EN write beats the one-shot clear.
        if (ctrl_wr) begin
            en_d   = din[CtrlEnBit];
            mode_d = din[CtrlModeMsb:CtrlModeLsb];
            im_d   = din[CtrlImBit];
            pend_d = 1'b0;
        end
        if (preset_wr) begin
            preset_d = din[CNT_W-1:0];
        end
        if (state_q == StInt) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            preset_q <= '0;
            en_q     <= 1'b0;
            mode_q   <= ModeOneShot;
            im_q     <= 1'b0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            preset_q <= preset_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            pend_q   <= pend_d;
            irq_q    <= pend_q & im_q;
        end
    end

    assign irq = irq_q;

    always_comb begin
        dout = '0;
        case (addr)
            AddrCtrl: begin
                dout[CtrlEnBit]               = en_q;
                dout[CtrlModeMsb:CtrlModeLsb] = mode_q;
                dout[CtrlImBit]               = im_q;
                dout[CtrlPendBit]             = pend_q;
            end
            AddrPreset: dout = 32'(preset_q);
            AddrCount:  dout = 32'(count_q);
            default:    dout = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: a vector table for the main one-shot flow plus
// hand-written sequences for auto-reload, INT/write collisions and reset.
module tb_timer_dev;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int checks;
    int failures;

    timer_dev #(.CNT_W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        int          reps;
        logic [1:0]  raddr;
        logic [31:0] exp;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[32];

    // One clock: drive inputs on the falling edge, return 1ns after the rising edge.
    task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        we   = w;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
        we  = 1'b0;
        din = '0;
    endtask

    task automatic chk(input string name, input logic [1:0] ra, input logic [31:0] exp);
        addr = ra;
        #1;
        checks++;
        if (dout !== exp) begin
            failures++;
            $display("FAIL %s: dout=%h expected %h", name, dout, exp);
        end
    endtask

    task automatic chk_irq(input string name, input logic exp);
        checks++;
        if (irq !== exp) begin
            failures++;
            $display("FAIL %s: irq=%b expected %b", name, irq, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 2'd0, 32'd0);
        cyc(1'b0, 2'd0, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        int exp_cnt[10];
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        we       = 1'b0;
        addr     = 2'd0;
        din      = '0;

        //        we    addr   din            reps raddr  exp           irq
        tbl[0]  = '{1'b1, 2'd1, 32'd5,         1, 2'd1, 32'd5,        1'b0};
        tbl[1]  = '{1'b1, 2'd0, 32'h09,        1, 2'd0, 32'h09,       1'b0};
        tbl[2]  = '{1'b0, 2'd0, 32'd0,         1, 2'd2, 32'd5,        1'b0};
        tbl[3]  = '{1'b0, 2'd0, 32'd0,         1, 2'd2, 32'd4,        1'b0};
        tbl[4]  = '{1'b0, 2'd0, 32'd0,         1, 2'd2, 32'd3,        1'b0};
        tbl[5]  = '{1'b0, 2'd0, 32'd0,         1, 2'd2, 32'd2,        1'b0};
        tbl[6]  = '{1'b0, 2'd0, 32'd0,         1, 2'd2, 32'd1,        1'b0};
        tbl[7]  = '{1'b0, 2'd0, 32'd0,         1, 2'd2, 32'd0,        1'b0};
        tbl[8]  = '{1'b0, 2'd0, 32'd0,         1, 2'd0, 32'h18,       1'b0};
        tbl[9]  = '{1'b0, 2'd0, 32'd0,         1, 2'd2, 32'd0,        1'b1};
        tbl[10] = '{1'b1, 2'd0, 32'h09,        1, 2'd0, 32'h09,       1'b1};
        tbl[11] = '{1'b0, 2'd0, 32'd0,         1, 2'd2, 32'd5,        1'b0};
        tbl[12] = '{1'b0, 2'd0, 32'd0,         1, 2'd2, 32'd4,        1'b0};
        tbl[13] = '{1'b1, 2'd0, 32'h08,        1, 2'd2, 32'd4,        1'b0};
        tbl[14] = '{1'b0, 2'd0, 32'd0,         9, 2'd2, 32'd4,        1'b0};
        tbl[15] = '{1'b1, 2'd0, 32'h09,        1, 2'd2, 32'd3,        1'b0};
        tbl[16] = '{1'b0, 2'd0, 32'd0,         1, 2'd2, 32'd2,        1'b0};
        tbl[17] = '{1'b1, 2'd1, 32'd7,         1, 2'd2, 32'd1,        1'b0};
        tbl[18] = '{1'b0, 2'd0, 32'd0,         1, 2'd2, 32'd0,        1'b0};
        tbl[19] = '{1'b0, 2'd0, 32'd0,         1, 2'd0, 32'h18,       1'b0};
        tbl[20] = '{1'b0, 2'd0, 32'd0,         1, 2'd1, 32'd7,        1'b1};
        tbl[21] = '{1'b1, 2'd1, 32'd0,         1, 2'd1, 32'd0,        1'b1};
        tbl[22] = '{1'b1, 2'd0, 32'h01,        1, 2'd0, 32'h01,       1'b1};
        tbl[23] = '{1'b0, 2'd0, 32'd0,         1, 2'd2, 32'd0,        1'b0};
        tbl[24] = '{1'b0, 2'd0, 32'd0,         1, 2'd0, 32'h01,       1'b0};
        tbl[25] = '{1'b0, 2'd0, 32'd0,         1, 2'd0, 32'h10,       1'b0};
        tbl[26] = '{1'b0, 2'd0, 32'd0,         1, 2'd0, 32'h10,       1'b0};
        tbl[27] = '{1'b1, 2'd3, 32'hffffffff,  1, 2'd3, 32'd0,        1'b0};
        tbl[28] = '{1'b0, 2'd0, 32'd0,         1, 2'd0, 32'h10,       1'b0};
        tbl[29] = '{1'b1, 2'd2, 32'h55,        1, 2'd2, 32'd0,        1'b0};
        tbl[30] = '{1'b0, 2'd0, 32'd0,         1, 2'd1, 32'd0,        1'b0};
        tbl[31] = '{1'b1, 2'd0, 32'h06,        1, 2'd0, 32'h06,       1'b0};

        // Reset must override a concurrent PRESET write.
        cyc(1'b1, 2'd1, 32'h55);
        rst = 1'b0;
        chk("rst_ctrl", 2'd0, 32'd0);
        chk("rst_preset", 2'd1, 32'd0);
        chk("rst_count", 2'd2, 32'd0);
        chk_irq("rst_irq", 1'b0);

        for (int i = 0; i < 32; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                cyc(tbl[i].we, tbl[i].addr, tbl[i].din);
                chk($sformatf("vec%0d_%0d", i, r), tbl[i].raddr, tbl[i].exp);
                chk_irq($sformatf("vec%0d_%0d_irq", i, r), tbl[i].exp_irq);
            end
        end

        // Auto-reload, PRESET=3: COUNT pattern repeats every 5 cycles.
        exp_cnt = '{3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
        do_reset();
        cyc(1'b1, 2'd1, 32'd3);
        cyc(1'b1, 2'd0, 32'h0B);
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 2'd0, 32'd0);
            chk($sformatf("reload_cnt%0d", k), 2'd2, 32'(exp_cnt[k-1]));
            chk_irq($sformatf("reload_irq%0d", k), k >= 6);
        end
        cyc(1'b1, 2'd0, 32'h0B);
        chk("reload_ctrl_clr", 2'd0, 32'h0B);
        chk_irq("reload_irq11", 1'b1);
        for (int k = 12; k <= 16; k++) begin
            cyc(1'b0, 2'd0, 32'd0);
            chk_irq($sformatf("reload_irq%0d", k), k == 16);
        end

        // CTRL write colliding with INT, IM=1.
        do_reset();
        cyc(1'b1, 2'd1, 32'd1);
        cyc(1'b1, 2'd0, 32'h09);
        cyc(1'b0, 2'd0, 32'd0);
        chk("coll_cnt1", 2'd2, 32'd1);
        cyc(1'b0, 2'd0, 32'd0);
        chk("coll_cnt0", 2'd2, 32'd0);
        cyc(1'b1, 2'd0, 32'h09);
        chk("coll_ctrl", 2'd0, 32'h19);
        chk_irq("coll_irq_a", 1'b0);
        cyc(1'b0, 2'd0, 32'd0);
        chk("coll_ctrl_b", 2'd0, 32'h19);
        chk_irq("coll_irq_b", 1'b1);

        // Same collision with IM=0.
        do_reset();
        cyc(1'b1, 2'd1, 32'd1);
        cyc(1'b1, 2'd0, 32'h01);
        cyc(1'b0, 2'd0, 32'd0);
        cyc(1'b0, 2'd0, 32'd0);
        cyc(1'b1, 2'd0, 32'h01);
        chk("coll_nim_ctrl", 2'd0, 32'h11);
        cyc(1'b0, 2'd0, 32'd0);
        chk("coll_nim_ctrl_b", 2'd0, 32'h11);
        chk_irq("coll_nim_irq_a", 1'b0);
        cyc(1'b0, 2'd0, 32'd0);
        chk_irq("coll_nim_irq_b", 1'b0);

        // Reset mid-count, with a concurrent CTRL write.
        do_reset();
        cyc(1'b1, 2'd1, 32'd5);
        cyc(1'b1, 2'd0, 32'h09);
        for (int k = 0; k < 4; k++) cyc(1'b0, 2'd0, 32'd0);
        chk("midrst_cnt2", 2'd2, 32'd2);
        rst = 1'b1;
        cyc(1'b1, 2'd0, 32'h09);
        rst = 1'b0;
        chk("midrst_ctrl", 2'd0, 32'd0);
        chk("midrst_preset", 2'd1, 32'd0);
        chk("midrst_count", 2'd2, 32'd0);
        chk_irq("midrst_irq", 1'b0);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 2'd0, 32'd0);
            chk_irq($sformatf("midrst_irq%0d", k), 1'b0);
            chk($sformatf("midrst_cnt%0d", k), 2'd2, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 Parameter CNT_W, default 32, COUNT/PRESET width; legal range 8..32.
REQ-002 clk  input  1  processor clock.
REQ-003 rst  input  1  one clock; reset is synchronous and active-high.
REQ-004 addr  input  2  word offset taken from PrAddr[3:2].
REQ-005 we  input  1  write strobe; qualified by the decoded device select.
REQ-006 din  input  32  write data, driven from PrWD.
REQ-007 dout  output  32  read data, returned to PrRD.
REQ-008 irq  output  1  interrupt request; connects to one HWInt[7:2] bit.

Function
REQ-009 Register map SHALL be: addr 0 CTRL (read/write); addr 1 PRESET (read/write); addr 2 COUNT (read-only); addr 3 reads 0 and ignores writes.
REQ-010 CTRL bits SHALL be: [0] EN; [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00); [3] IM interrupt mask; [4] PEND (read-only); [31:5] read 0.
REQ-011 dout SHALL be combinational from addr, with zero read latency; PRESET and COUNT are zero-extended to 32 bits.
REQ-012 Writes SHALL take effect at the clk edge where we=1; din bits above CNT_W are discarded.
REQ-013 FSM states SHALL be IDLE, LOAD, CNT and INT.
REQ-014 IDLE: when EN=1, go to LOAD; otherwise hold.
REQ-015 LOAD: COUNT <= PRESET, then go to CNT.
REQ-016 CNT with EN=0: COUNT and state are held (pause).
REQ-017 CNT with EN=1 and COUNT>1: COUNT <= COUNT-1.
REQ-018 CNT with EN=1 and COUNT<=1: COUNT <= 0, then go to INT.
REQ-019 INT: PEND <= 1. MODE 00: EN <= 0 and go to IDLE. MODE 01: go to LOAD.
REQ-020 Period in MODE 01 SHALL be max(PRESET,1)+2 cycles between consecutive INT states.
REQ-021 irq SHALL be registered as PEND & IM and SHALL be asserted in the cycle after PEND sets.
REQ-022 Any CTRL write SHALL clear PEND; if that write coincides with an INT cycle, the set wins and PEND stays 1.
REQ-023 A PRESET write during CNT SHALL NOT alter COUNT; it takes effect at the next LOAD.
REQ-024 A CTRL write with EN=0 during LOAD or CNT SHALL freeze state and COUNT; writing EN=1 again resumes without reload.
REQ-025 A CTRL write in the same cycle that INT clears EN (MODE 00) SHALL win for EN.
REQ-026 COUNT SHALL never underflow below 0 and never wrap.

Reset
REQ-027 With rst=1 at a clk edge, the following SHALL apply on that edge, overriding any concurrent write:
- CTRL <= 0
- PRESET <= 0
- COUNT <= 0
- state <= IDLE
- irq <= 0
REQ-028 Reset asserted mid-count SHALL abandon the count; no irq SHALL follow.

Structure
REQ-029 Package timer_pkg SHALL hold the FSM state encoding, the register offsets (CTRL=0, PRESET=1, COUNT=2) and the CTRL bit-position constants.
REQ-030 The block SHALL be a single module with no sub-modules; the address decode that generates we stays in the system bridge.

Verification
REQ-031 Write PRESET=5, then CTRL=0x09 (EN, one-shot, IM) -> COUNT reads 5,4,3,2,1,0; irq rises 1 cycle after INT; CTRL reads 0x18 (EN=0, IM=1, PEND=1).
REQ-032 PRESET=3, CTRL=0x0B (auto-reload, IM) -> INT recurs every 5 cycles; irq stays high until a CTRL write of 0x0B, which drops it the following cycle.
REQ-033 During CNT with COUNT=4, write CTRL=0x08 -> COUNT holds 4 for 10 cycles; then write CTRL=0x09 -> counting resumes from 4.
REQ-034 CTRL write in the same cycle as INT -> PEND remains 1 and irq remains 1 (with IM=1); with IM=0, irq stays 0 while PEND reads 1.
REQ-035 PRESET=0 in one-shot mode -> INT follows after exactly 1 CNT cycle; PRESET write of 7 mid-count -> current COUNT is unaffected.
REQ-036 Assert rst while COUNT=2 -> all registers read 0 next cycle; irq stays 0 for 20 cycles afterwards.
